div_unit: RTL



---
 rtl/alu_pkg.sv | 14 +
 rtl/div_iter_step.sv | 13 +
 rtl/div_unit.sv | 108 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU and divider operation codes
package alu_pkg;
   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
      ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
   } alu_op_t;
   typedef enum logic [1:0] {DIV, DIVU, REM, REMU} divop_t;
   function automatic logic is_signed_op(input divop_t o);
      return !o[0];
   endfunction
   function automatic logic is_rem_op(input divop_t o);
      return o[1];
   endfunction
endpackage

// File: rtl/div_iter_step.sv
// div_iter_step: one restoring shift-subtract step of the radix-2 divider
module div_iter_step #(parameter int W = 32) (
   input  logic [W:0]   rem_in,
   input  logic         dbit,
   input  logic [W-1:0] divisor,
   output logic [W:0]   rem_out,
   output logic         q_bit
);
   logic [W+1:0] shifted;
   assign shifted = {rem_in, dbit};
   assign q_bit = shifted >= {2'b0, divisor};
   assign rem_out = q_bit ? (W+1)'(shifted - {2'b0, divisor}) : shifted[W:0];
endmodule

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 divider for DIV/DIVU/REM/REMU and their word forms
module div_unit import alu_pkg::*; #(parameter int XLEN = 32) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [1:0]      op,
   input  logic            is_word_op,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   localparam int CW = $clog2(XLEN);
   state_t state;
   logic [XLEN:0] rem, rem_next;
   logic [XLEN-1:0] quo, dvsr, quo_next, q_fin, r_fin;
   logic [XLEN-1:0] ext_a, ext_b, abs_a, abs_b, min_val, spec_res;
   logic [CW-1:0] cnt;
   logic neg_q, neg_r, word_q, sgn, sa, sb, div_zero, ovf, q_bit;
   divop_t op_q;
   function automatic logic [XLEN-1:0] ext32(input logic [31:0] v, input logic s);
      return s ? XLEN'($signed(v)) : XLEN'(v);
   endfunction
   function automatic logic [XLEN-1:0] pick(input divop_t o, input logic [XLEN-1:0] q,
                                            input logic [XLEN-1:0] r, input logic w);
      logic [XLEN-1:0] s;
      s = is_rem_op(o) ? r : q;
      return w ? ext32(s[31:0], 1'b1) : s;
   endfunction
   div_iter_step #(.W(XLEN)) u_step (
      .rem_in(rem), .dbit(quo[XLEN-1]), .divisor(dvsr), .rem_out(rem_next), .q_bit(q_bit)
   );
   assign in_ready = state == IDLE;
   always_comb begin
      sgn      = is_signed_op(divop_t'(op));
      ext_a    = is_word_op ? ext32(a[31:0], sgn) : a;
      ext_b    = is_word_op ? ext32(b[31:0], sgn) : b;
      sa       = sgn & ext_a[XLEN-1];
      sb       = sgn & ext_b[XLEN-1];
      abs_a    = sa ? -ext_a : ext_a;
      abs_b    = sb ? -ext_b : ext_b;
      min_val  = is_word_op ? ext32(32'h8000_0000, 1'b1) : {1'b1, (XLEN-1)'(0)};
      div_zero = ext_b == '0;
      ovf      = sgn && ext_b == '1 && ext_a == min_val;
      spec_res = pick(divop_t'(op), div_zero ? '1 : ext_a, div_zero ? ext_a : '0, is_word_op);
      quo_next = {quo[XLEN-2:0], q_bit};
      q_fin    = neg_q ? -quo_next : quo_next;
      r_fin    = neg_r ? -rem_next[XLEN-1:0] : rem_next[XLEN-1:0];
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         result    <= '0;
         rem       <= '0;
         quo       <= '0;
         dvsr      <= '0;
         cnt       <= '0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
         word_q    <= 1'b0;
         op_q      <= DIV;
      end else if (flush) begin
         state     <= IDLE;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               op_q   <= divop_t'(op);
               word_q <= is_word_op;
               neg_q  <= sa ^ sb;
               neg_r  <= sa;
               if (div_zero || ovf) begin
                  result    <= spec_res;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  rem   <= '0;
                  // word dividends start at the top so the MSB-first shift sees them first
                  quo   <= is_word_op ? abs_a << (XLEN-32) : abs_a;
                  dvsr  <= abs_b;
                  cnt   <= is_word_op ? CW'(31) : CW'(XLEN-1);
                  state <= BUSY;
               end
            end
            BUSY: begin
               rem <= rem_next;
               quo <= quo_next;
               cnt <= cnt - 1'b1;
               if (cnt == '0) begin
                  result    <= pick(op_q, q_fin, r_fin, word_q);
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: if (out_ready) begin
               out_valid <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
